usb_state_machine: RTL and testbench

//  ULPI link-side controller between the USB PHY and the internal packet datapath.
//  - Receive: separates RX CMD bytes from data bytes on the PHY bus and hands data bytes inward one at a time.
//  - Transmit: serialises a 66-byte internal packet onto the PHY bus with the nxt handshake, then ends it with stp.

---
 rtl/usb_pkg.sv | 16 +
 rtl/usb_state_machine_if.sv | 25 ++
 rtl/usb_tx_shift_reg.sv | 37 +++
 rtl/usb_state_machine.sv | 89 ++++++++
 tb/tb_usb_state_machine.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/usb_pkg.sv
// Shared types and constants for the ULPI link-side controller.
package usb_pkg;

    localparam int         TX_BYTES       = 66;
    localparam int         TX_W           = 8 * TX_BYTES;
    localparam logic [7:0] ULPI_IDLE_BYTE = 8'h00;

    typedef enum logic [2:0] {
        IDLE,
        RX_TURN,
        RX,
        TX,
        TX_STP
    } usb_state_e;

endpackage

// File: rtl/usb_state_machine_if.sv
// PHY-side ULPI signals plus the internal packet/byte datapath, as seen by the link controller.
interface usb_state_machine_if;
    import usb_pkg::*;

    logic            dir;
    logic            nxt;
    logic [7:0]      data_in;
    logic            shift_out;
    logic [TX_W-1:0] internal_data_in;
    logic [7:0]      data_out;
    logic            stp;
    logic            new_byte;
    logic [7:0]      internal_data_out;

    modport master (
        output dir, nxt, data_in, shift_out, internal_data_in,
        input  data_out, stp, new_byte, internal_data_out
    );

    modport slave (
        input  dir, nxt, data_in, shift_out, internal_data_in,
        output data_out, stp, new_byte, internal_data_out
    );

endinterface

// File: rtl/usb_tx_shift_reg.sv
// Packet shift register: load a full packet, shift one byte per accepted PHY handshake.
module usb_tx_shift_reg
    import usb_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            shift,
    input  logic [TX_W-1:0] din,
    output logic [7:0]      top_byte,
    output logic [7:0]      next_byte,
    output logic            last_byte
);

    logic [TX_W-1:0] sr;
    logic [6:0]      byte_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sr       <= '0;
            byte_cnt <= '0;
        end else if (load) begin
            sr       <= din;
            byte_cnt <= '0;
        end else if (shift) begin
            sr <= {sr[TX_W-9:0], 8'h00};
            // Counter parks on the final byte; the FSM leaves TX on that handshake.
            if (!last_byte)
                byte_cnt <= byte_cnt + 7'd1;
        end
    end

    assign top_byte  = sr[TX_W-1 -: 8];
    assign next_byte = sr[TX_W-9 -: 8];
    assign last_byte = (byte_cnt == 7'(TX_BYTES - 1));

endmodule

// File: rtl/usb_state_machine.sv
// ULPI link controller: splits RX CMD from RX data, serialises 66-byte packets with nxt/stp.
module usb_state_machine
    import usb_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    usb_state_machine_if.slave bus
);

    usb_state_e state;
    logic [7:0] data_out_q;
    logic       stp_q;
    logic       new_byte_q;
    logic [7:0] rx_byte_q;

    logic [7:0] top_byte;
    logic [7:0] next_byte;
    logic       last_byte;
    logic       tx_load;
    logic       tx_shift;

    assign tx_load  = (state == IDLE) && !bus.dir && bus.shift_out;
    assign tx_shift = (state == TX) && !bus.dir && bus.nxt;

    usb_tx_shift_reg u_tx_sr (
        .clk       (clk),
        .rst       (rst),
        .load      (tx_load),
        .shift     (tx_shift),
        .din       (bus.internal_data_in),
        .top_byte  (top_byte),
        .next_byte (next_byte),
        .last_byte (last_byte)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            data_out_q <= ULPI_IDLE_BYTE;
            stp_q      <= 1'b0;
            new_byte_q <= 1'b0;
            rx_byte_q  <= 8'h00;
        end else begin
            data_out_q <= ULPI_IDLE_BYTE;
            stp_q      <= 1'b0;
            new_byte_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.dir)
                        state <= RX_TURN;
                    else if (bus.shift_out) begin
                        state      <= TX;
                        data_out_q <= bus.internal_data_in[TX_W-1 -: 8];
                    end
                end
                RX_TURN: state <= bus.dir ? RX : IDLE;
                RX: begin
                    if (!bus.dir)
                        state <= IDLE;
                    else if (bus.nxt) begin
                        rx_byte_q  <= bus.data_in;
                        new_byte_q <= 1'b1;
                    end
                end
                TX: begin
                    // PHY grabbing the bus aborts the packet without stp.
                    if (bus.dir)
                        state <= RX_TURN;
                    else if (bus.nxt) begin
                        if (last_byte) begin
                            state <= TX_STP;
                            stp_q <= 1'b1;
                        end else
                            data_out_q <= next_byte;
                    end else
                        data_out_q <= top_byte;
                end
                TX_STP:  state <= bus.dir ? RX_TURN : IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.data_out          = data_out_q;
    assign bus.stp               = stp_q;
    assign bus.new_byte          = new_byte_q;
    assign bus.internal_data_out = rx_byte_q;

endmodule

// File: tb/tb_usb_state_machine.sv
// Scoreboard bench for usb_state_machine: directed RX/TX/throttle/abort vectors.
module tb_usb_state_machine;
    import usb_pkg::*;

    localparam logic [1:0] K_RX  = 2'd0;
    localparam logic [1:0] K_TX  = 2'd1;
    localparam logic [1:0] K_STP = 2'd2;

    typedef struct {
        logic [1:0] kind;
        logic [7:0] val;
    } exp_t;

    exp_t       q[$];
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       phy_ack = 1'b0;
    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] pkt [TX_BYTES];

    always #5 clk = ~clk;

    usb_state_machine_if bus();

    usb_state_machine dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] k, input logic [7:0] v);
        exp_t e;
        e.kind = k;
        e.val  = v;
        q.push_back(e);
    endtask

    // Pops the oldest expectation whenever the DUT presents something.
    task automatic mon(input logic [1:0] kind, input logic [7:0] act, input string name);
        exp_t e;
        if (q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: unexpected output %h with nothing expected", name, act);
        end else begin
            e = q.pop_front();
            if (e.kind != kind) begin
                n_cmp++;
                n_bad++;
                $display("FAIL %s: output kind %0d, expected kind %0d", name, kind, e.kind);
            end else
                check(name, act, e.val);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (bus.new_byte) mon(K_RX,  bus.internal_data_out, "rx_byte");
                if (phy_ack)      mon(K_TX,  bus.data_out,          "tx_byte");
                if (bus.stp)      mon(K_STP, bus.data_out,          "stp_data");
            end
        end
    end

    task automatic load_pkt(input int mode);
        for (int i = 0; i < TX_BYTES; i++) begin
            case (mode)
                0:       pkt[i] = i[0] ? 8'hBB : 8'hAA;
                1:       pkt[i] = 8'h40 + 8'(i);
                default: pkt[i] = 8'hC0 ^ 8'(i);
            endcase
            bus.internal_data_in[TX_W-1-8*i -: 8] = pkt[i];
        end
        bus.shift_out = 1'b1;
        tick;
        bus.shift_out = 1'b0;
    endtask

    task automatic send_bytes(input int from, input int to);
        for (int i = from; i < to; i++) begin
            bus.nxt = 1'b1;
            phy_ack = 1'b1;
            push(K_TX, pkt[i]);
            tick;
        end
        bus.nxt = 1'b0;
        phy_ack = 1'b0;
    endtask

    task automatic finish_stp(input string tag);
        push(K_STP, ULPI_IDLE_BYTE);
        tick;
        check({tag, "_idle_stp"}, {7'd0, bus.stp}, 8'h00);
        check({tag, "_idle_data"}, bus.data_out, 8'h00);
    endtask

    initial begin
        bus.dir = 1'b0;
        bus.nxt = 1'b0;
        bus.data_in = 8'h00;
        bus.shift_out = 1'b0;
        bus.internal_data_in = '0;

        // Reset
        rst = 1'b1;
        tick;
        tick;
        check("rst_new_byte", {7'd0, bus.new_byte}, 8'h00);
        check("rst_stp", {7'd0, bus.stp}, 8'h00);
        check("rst_data_out", bus.data_out, 8'h00);
        check("rst_rx_byte", bus.internal_data_out, 8'h00);
        rst = 1'b0;
        tick;

        // RX CMD only: nothing handed inward
        bus.dir = 1'b1;
        bus.data_in = 8'hFF;
        for (int i = 0; i < 4; i++) begin
            tick;
            check("rxcmd_new_byte", {7'd0, bus.new_byte}, 8'h00);
        end
        bus.dir = 1'b0;
        tick;
        tick;
        check("rxcmd_rx_byte", bus.internal_data_out, 8'h00);

        // RX data after turnaround and an RX CMD
        bus.dir = 1'b1;
        tick;
        bus.data_in = 8'h10;
        tick;
        tick;
        bus.nxt = 1'b1;
        bus.data_in = 8'hFF;
        push(K_RX, 8'hFF);
        tick;
        bus.data_in = 8'hAA;
        push(K_RX, 8'hAA);
        tick;
        bus.nxt = 1'b0;
        bus.data_in = 8'h10;
        tick;
        check("rx_pulse_end", {7'd0, bus.new_byte}, 8'h00);
        bus.dir = 1'b0;
        tick;
        check("rx_hold", bus.internal_data_out, 8'hAA);
        tick;

        // TX full packet, nxt always high
        load_pkt(0);
        send_bytes(0, TX_BYTES);
        finish_stp("tx");
        tick;

        // TX with 3-cycle throttle mid-packet
        load_pkt(1);
        send_bytes(0, 11);
        for (int i = 0; i < 3; i++) begin
            check("throttle_hold", bus.data_out, pkt[11]);
            tick;
        end
        send_bytes(11, TX_BYTES);
        finish_stp("thr");
        tick;

        // Abort: PHY takes the bus after byte 10
        load_pkt(2);
        send_bytes(0, 11);
        bus.dir = 1'b1;
        tick;
        check("abort_data_out", bus.data_out, 8'h00);
        check("abort_stp", {7'd0, bus.stp}, 8'h00);
        tick;
        bus.nxt = 1'b1;
        bus.data_in = 8'h5A;
        push(K_RX, 8'h5A);
        tick;
        bus.nxt = 1'b0;
        tick;
        bus.dir = 1'b0;
        tick;
        tick;
        check("abort_no_stp", {7'd0, bus.stp}, 8'h00);
        load_pkt(2);
        check("restart_byte0", bus.data_out, pkt[0]);
        send_bytes(0, TX_BYTES);
        finish_stp("restart");

        for (int i = 0; i < 20 && q.size() != 0; i++)
            tick;
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d outputs never seen, expected 0", q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
